enemy_sprite_ctrl: RTL and testbench
====================================

# enemy_sprite_ctrl

Parametrised walking-enemy sprite controller for the SuperMario display pipeline, successor to the single-frame-pair turtle controller. It turns toggle-style event lines from the collision/physics logic (wall hit, stomp, animation tick) into a sprite id, facing bit and shell flags. The block adds configurable walk/shell frame counts, a kicked-shell sliding mode, timed revival from shell back to walking, and despawn. The sprite id feeds the shared Object lookup for width and height.

## Interface
- WALK_FRAMES, 2: walk animation frames per direction (1..8).
- SHELL_FRAMES, 4: shell spin frames (1..8).
- ID_WALK_L, 32: first left-facing walk id.
- ID_WALK_R, 34: first right-facing walk id.
- ID_SHELL, 21: first shell id.
- ID_NULL, 63: id shown when hidden.
- REVIVE_TICKS, 8: idle-shell anim ticks before waking (1..255).
- WAKE_TICKS, 4: anim ticks spent in WAKING (1..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset; synchronous, active-low.
- clk_walk_anim  in  1  animation tick; every level change is one tick event.
- initial_show  in  1  level; 1 = enemy spawned and visible.
- collapsion_impulse  in  1  toggle; every level change is one wall-collision event.
- press_impulse  in  1  toggle; every level change is one stomp/kick event.
- kick_dir  in  1  facing applied when an idle shell is kicked (0 right, 1 left).
- id  out  6  sprite id, combinational from registered state.
- oriental  out  1  facing: 0 right, 1 left.
- w, h  out  11  sprite size from Object lookup of id.
- shell  out  1  1 in SHELL_IDLE, SHELL_SLIDE, WAKING.
- shell_anim  out  1  1 in SHELL_SLIDE only.
- moving  out  1  1 in WALK or SHELL_SLIDE.
- stomp_pulse  out  1  one-cycle pulse per accepted press event.

## Operation
- Event detect: each toggle input has a prev register updated every cycle. An event is input != prev. Reset loads prev with the current input levels, so there is no spurious event on reset release.
- Reset (rstn=0 at an edge) sets: state HIDDEN, oriental=1, walk_frame=0, shell_frame=0, counter=0, stomp_pulse=0.
- States:
  - HIDDEN: id=ID_NULL. Goes to WALK at the edge where initial_show=1. Events are ignored.
  - Any state except HIDDEN: initial_show=0 returns to HIDDEN with the reset values (despawn). This has priority over all events.
  - WALK: a tick advances walk_frame modulo WALK_FRAMES. A collision toggles oriental. A press goes to SHELL_IDLE with counter=0 and shell_frame=0.
  - SHELL_IDLE: a tick increments counter. When counter reaches REVIVE_TICKS, go to WAKING with counter=0. A press goes to SHELL_SLIDE with oriental=kick_dir. A collision is ignored.
  - SHELL_SLIDE: a tick advances shell_frame modulo SHELL_FRAMES. A collision toggles oriental. A press goes to SHELL_IDLE with counter=0 and shell_frame=0.
  - WAKING: a tick increments counter and toggles a blink bit. When counter reaches WAKE_TICKS, go to WALK with walk_frame=0 and counter=0. A press goes to SHELL_IDLE with counter=0. A collision is ignored.
- Simultaneous events in one cycle:
  - A press transition wins over tick effects.
  - The collision flip still applies if the current state honours collisions, but not when the press also sets oriental=kick_dir; kick_dir wins.
- id mapping:
  - HIDDEN: ID_NULL.
  - WALK: (oriental ? ID_WALK_L : ID_WALK_R) + walk_frame.
  - SHELL_IDLE: ID_SHELL.
  - SHELL_SLIDE: ID_SHELL + shell_frame.
  - WAKING: ID_SHELL when blink=0, walk base + 0 when blink=1.
- Arithmetic: frames are 3 bits and counter is 8 bits. Counters never exceed their parameter value, so nothing wraps.
- stomp_pulse is high for exactly the cycle after each edge where a press event is accepted, i.e. any state except HIDDEN.

## Timing
- An input toggle sampled at edge k is an event at edge k. State, id and flags change just after edge k, so latency is one edge.
- Only one event per input is seen per cycle. Toggles faster than clk are lost by design.
- Reset mid-slide or mid-wake drops to HIDDEN at that edge. Outputs return to id=ID_NULL, oriental=1, shell=0, shell_anim=0, moving=0, stomp_pulse=0.

## Test plan
- Walk cycle: reset, then initial_show=1. id=32. Each tick gives 33, 32, 33. One collision gives id 34+frame and oriental=0.
- Stomp and revive: from WALK, one press gives id=21, shell=1 and a single stomp_pulse. After 8 ticks the block is in WAKING with id alternating 32/21. After 4 more ticks it is in WALK with id=32.
- Kick: from SHELL_IDLE, press with kick_dir=0 gives shell_anim=1, moving=1, oriental=0. Ticks give id 22, 23, 24, 21. A collision gives oriental=1.
- Simultaneous events: in WALK, press, collision and tick in the same cycle give SHELL_IDLE. oriental is flipped, walk_frame is unchanged, and exactly one stomp_pulse occurs.
- Despawn and reset: drop initial_show mid-slide gives id=63 and all flags 0. Assert rstn=0 with the toggle inputs at 1, release it, and check that no event fires.

Source files
------------

// File: rtl/enemy_sprite_if.sv
// Event/sprite bundle between the physics logic and the enemy sprite controller.
interface enemy_sprite_if;
    logic        clk_walk_anim;
    logic        initial_show;
    logic        collapsion_impulse;
    logic        press_impulse;
    logic        kick_dir;
    logic [5:0]  id;
    logic        oriental;
    logic [10:0] w;
    logic [10:0] h;
    logic        shell;
    logic        shell_anim;
    logic        moving;
    logic        stomp_pulse;

    modport slave (
        input  clk_walk_anim, initial_show, collapsion_impulse, press_impulse, kick_dir,
        output id, oriental, w, h, shell, shell_anim, moving, stomp_pulse
    );

    modport master (
        output clk_walk_anim, initial_show, collapsion_impulse, press_impulse, kick_dir,
        input  id, oriental, w, h, shell, shell_anim, moving, stomp_pulse
    );
endinterface

// File: rtl/enemy_sprite_ctrl.sv
// Walking-enemy sprite controller: turns toggle events into sprite id, facing and shell flags.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_HIDDEN     | not spawned, id shows ID_NULL, all events ignored
// S_WALK       | walking, ticks animate, collisions flip facing
// S_SHELL_IDLE | stomped shell at rest, ticks count towards revival
// S_SHELL_SLIDE| kicked shell sliding, ticks spin, collisions flip facing
// S_WAKING     | shell about to revive, ticks blink between shell and walker
module enemy_sprite_ctrl #(
    parameter int WALK_FRAMES  = 2,
    parameter int SHELL_FRAMES = 4,
    parameter int ID_WALK_L    = 32,
    parameter int ID_WALK_R    = 34,
    parameter int ID_SHELL     = 21,
    parameter int ID_NULL      = 63,
    parameter int REVIVE_TICKS = 8,
    parameter int WAKE_TICKS   = 4
) (
    input logic            clk,
    input logic            rstn,
    enemy_sprite_if.slave  bus
);

    localparam logic [2:0] S_HIDDEN      = 3'd0;
    localparam logic [2:0] S_WALK        = 3'd1;
    localparam logic [2:0] S_SHELL_IDLE  = 3'd2;
    localparam logic [2:0] S_SHELL_SLIDE = 3'd3;
    localparam logic [2:0] S_WAKING      = 3'd4;

    localparam logic [2:0] WALK_LAST   = 3'(WALK_FRAMES - 1);
    localparam logic [2:0] SHELL_LAST  = 3'(SHELL_FRAMES - 1);
    localparam logic [7:0] REVIVE_CNT  = 8'(REVIVE_TICKS);
    localparam logic [7:0] WAKE_CNT    = 8'(WAKE_TICKS);

    // Object lookup sizes: walkers are one tile wide and a tile and a half tall, shells are square.
    localparam logic [10:0] OBJ_W      = 11'd16;
    localparam logic [10:0] WALK_H     = 11'd24;
    localparam logic [10:0] SHELL_H    = 11'd16;

    logic [2:0] state_q, state_d;
    logic       oriental_q, oriental_d;
    logic [2:0] walk_frame_q, walk_frame_d;
    logic [2:0] shell_frame_q, shell_frame_d;
    logic [7:0] counter_q, counter_d;
    logic       blink_q, blink_d;
    logic       stomp_q, stomp_d;
    logic       tick_prev_q, col_prev_q, press_prev_q;

    logic       tick_ev, col_ev, press_ev;
    logic [7:0] counter_inc;

    assign tick_ev     = bus.clk_walk_anim != tick_prev_q;
    assign col_ev      = bus.collapsion_impulse != col_prev_q;
    assign press_ev    = bus.press_impulse != press_prev_q;
    assign counter_inc = counter_q + 8'd1;

    // Next-state logic; despawn overrides every event, press overrides tick effects.
    always_comb begin
        state_d       = state_q;
        oriental_d    = oriental_q;
        walk_frame_d  = walk_frame_q;
        shell_frame_d = shell_frame_q;
        counter_d     = counter_q;
        blink_d       = blink_q;
        stomp_d       = 1'b0;
        if (!bus.initial_show) begin
            state_d       = S_HIDDEN;
            oriental_d    = 1'b1;
            walk_frame_d  = 3'd0;
            shell_frame_d = 3'd0;
            counter_d     = 8'd0;
            blink_d       = 1'b0;
        end else begin
            case (state_q)
                S_HIDDEN: begin
                    state_d = S_WALK;
                end
                S_WALK: begin
                    if (col_ev) oriental_d = ~oriental_q;
                    if (press_ev) begin
                        state_d       = S_SHELL_IDLE;
                        counter_d     = 8'd0;
                        shell_frame_d = 3'd0;
                        stomp_d       = 1'b1;
                    end else if (tick_ev) begin
                        walk_frame_d = (walk_frame_q == WALK_LAST) ? 3'd0 : walk_frame_q + 3'd1;
                    end
                end
                S_SHELL_IDLE: begin
                    if (press_ev) begin
                        state_d    = S_SHELL_SLIDE;
                        oriental_d = bus.kick_dir;
                        stomp_d    = 1'b1;
                    end else if (tick_ev) begin
                        if (counter_inc == REVIVE_CNT) begin
                            state_d   = S_WAKING;
                            counter_d = 8'd0;
                            blink_d   = 1'b0;
                        end else begin
                            counter_d = counter_inc;
                        end
                    end
                end
                S_SHELL_SLIDE: begin
                    if (col_ev) oriental_d = ~oriental_q;
                    if (press_ev) begin
                        state_d       = S_SHELL_IDLE;
                        counter_d     = 8'd0;
                        shell_frame_d = 3'd0;
                        stomp_d       = 1'b1;
                    end else if (tick_ev) begin
                        shell_frame_d = (shell_frame_q == SHELL_LAST) ? 3'd0 : shell_frame_q + 3'd1;
                    end
                end
                S_WAKING: begin
                    if (press_ev) begin
                        state_d       = S_SHELL_IDLE;
                        counter_d     = 8'd0;
                        shell_frame_d = 3'd0;
                        blink_d       = 1'b0;
                        stomp_d       = 1'b1;
                    end else if (tick_ev) begin
                        blink_d = ~blink_q;
                        if (counter_inc == WAKE_CNT) begin
                            state_d      = S_WALK;
                            walk_frame_d = 3'd0;
                            counter_d    = 8'd0;
                            blink_d      = 1'b0;
                        end else begin
                            counter_d = counter_inc;
                        end
                    end
                end
                default: begin
                    state_d = S_HIDDEN;
                end
            endcase
        end
    end

    // State registers; reset captures current input levels so release creates no events.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_HIDDEN;
            oriental_q    <= 1'b1;
            walk_frame_q  <= 3'd0;
            shell_frame_q <= 3'd0;
            counter_q     <= 8'd0;
            blink_q       <= 1'b0;
            stomp_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            oriental_q    <= oriental_d;
            walk_frame_q  <= walk_frame_d;
            shell_frame_q <= shell_frame_d;
            counter_q     <= counter_d;
            blink_q       <= blink_d;
            stomp_q       <= stomp_d;
        end
        tick_prev_q  <= bus.clk_walk_anim;
        col_prev_q   <= bus.collapsion_impulse;
        press_prev_q <= bus.press_impulse;
    end

    logic [5:0]  walk_base;
    logic [5:0]  id_c;
    logic [31:0] id_ext;

    assign walk_base = oriental_q ? 6'(ID_WALK_L) : 6'(ID_WALK_R);
    assign id_ext    = {26'd0, id_c};

    // Sprite id from registered state.
    always_comb begin
        id_c = 6'(ID_NULL);
        case (state_q)
            S_WALK:        id_c = walk_base + {3'd0, walk_frame_q};
            S_SHELL_IDLE:  id_c = 6'(ID_SHELL);
            S_SHELL_SLIDE: id_c = 6'(ID_SHELL) + {3'd0, shell_frame_q};
            S_WAKING:      id_c = blink_q ? walk_base : 6'(ID_SHELL);
            default:       id_c = 6'(ID_NULL);
        endcase
    end

    // Object lookup of the displayed id; unknown ids and the null id are zero-sized.
    always_comb begin
        bus.w = 11'd0;
        bus.h = 11'd0;
        if (id_ext == 32'(ID_NULL)) begin
            bus.w = 11'd0;
            bus.h = 11'd0;
        end else if (id_ext >= 32'(ID_SHELL) && id_ext < 32'(ID_SHELL + SHELL_FRAMES)) begin
            bus.w = OBJ_W;
            bus.h = SHELL_H;
        end else if ((id_ext >= 32'(ID_WALK_L) && id_ext < 32'(ID_WALK_L + WALK_FRAMES)) ||
                     (id_ext >= 32'(ID_WALK_R) && id_ext < 32'(ID_WALK_R + WALK_FRAMES))) begin
            bus.w = OBJ_W;
            bus.h = WALK_H;
        end
    end

    assign bus.id          = id_c;
    assign bus.oriental    = oriental_q;
    assign bus.shell       = (state_q == S_SHELL_IDLE) || (state_q == S_SHELL_SLIDE) || (state_q == S_WAKING);
    assign bus.shell_anim  = (state_q == S_SHELL_SLIDE);
    assign bus.moving      = (state_q == S_WALK) || (state_q == S_SHELL_SLIDE);
    assign bus.stomp_pulse = stomp_q;

endmodule

// File: tb/tb_enemy_sprite_ctrl.sv
// Vector bench for enemy_sprite_ctrl: each record toggles inputs for one cycle and
// states the outputs expected just after that edge.
module tb_enemy_sprite_ctrl;

    logic clk = 1'b0;
    logic rstn;

    enemy_sprite_if bus();

    enemy_sprite_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       show;
        logic       tk;
        logic       cl;
        logic       pr;
        logic       kd;
        logic [5:0] id;
        logic       ori;
        logic       sh;
        logic       sa;
        logic       mv;
        logic       sp;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    function automatic vec_t v(bit show, bit tk, bit cl, bit pr, bit kd,
                               int id, bit ori, bit sh, bit sa, bit mv, bit sp);
        vec_t t;
        t.rstn = 1'b1; t.show = show; t.tk = tk; t.cl = cl; t.pr = pr; t.kd = kd;
        t.id = 6'(id); t.ori = ori; t.sh = sh; t.sa = sa; t.mv = mv; t.sp = sp;
        return t;
    endfunction

    function automatic int exp_w(logic [5:0] id);
        case (id)
            6'd21, 6'd22, 6'd23, 6'd24, 6'd32, 6'd33, 6'd34, 6'd35: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_h(logic [5:0] id);
        case (id)
            6'd21, 6'd22, 6'd23, 6'd24: return 16;
            6'd32, 6'd33, 6'd34, 6'd35: return 24;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL step %0d %s: got %0d expected %0d", step_no, name, act, expv);
        end
    endtask

    task automatic compare_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL step %0d scoreboard: got empty queue expected one entry", step_no);
            return;
        end
        e = exp_q.pop_front();
        chk("id",          int'(bus.id),          int'(e.id));
        chk("oriental",    int'(bus.oriental),    int'(e.ori));
        chk("shell",       int'(bus.shell),       int'(e.sh));
        chk("shell_anim",  int'(bus.shell_anim),  int'(e.sa));
        chk("moving",      int'(bus.moving),      int'(e.mv));
        chk("stomp_pulse", int'(bus.stomp_pulse), int'(e.sp));
        chk("w",           int'(bus.w),           exp_w(e.id));
        chk("h",           int'(bus.h),           exp_h(e.id));
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        rstn             = t.rstn;
        bus.initial_show = t.show;
        bus.kick_dir     = t.kd;
        if (t.tk) bus.clk_walk_anim      = ~bus.clk_walk_anim;
        if (t.cl) bus.collapsion_impulse = ~bus.collapsion_impulse;
        if (t.pr) bus.press_impulse      = ~bus.press_impulse;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        step_no++;
        compare_out();
    endtask

    initial begin
        vec_t r;

        rstn                   = 1'b0;
        bus.clk_walk_anim      = 1'b0;
        bus.initial_show       = 1'b0;
        bus.collapsion_impulse = 1'b0;
        bus.press_impulse      = 1'b0;
        bus.kick_dir           = 1'b0;

        // show tk cl pr kd | id ori sh sa mv sp
        tbl.push_back(v(0,0,0,0,0, 63,1,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0, 63,1,0,0,0,0));
        tbl.push_back(v(0,0,0,1,0, 63,1,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 32,1,0,0,1,0));
        tbl.push_back(v(1,1,0,0,0, 33,1,0,0,1,0));
        tbl.push_back(v(1,1,0,0,0, 32,1,0,0,1,0));
        tbl.push_back(v(1,1,0,0,0, 33,1,0,0,1,0));
        tbl.push_back(v(1,0,1,0,0, 35,0,0,0,1,0));
        tbl.push_back(v(1,1,0,0,0, 34,0,0,0,1,0));
        tbl.push_back(v(1,0,1,0,0, 32,1,0,0,1,0));
        tbl.push_back(v(1,0,0,1,0, 21,1,1,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 21,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 21,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,0, 21,1,1,0,0,0));
        for (int i = 0; i < 6; i++) tbl.push_back(v(1,1,0,0,0, 21,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 21,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 32,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 21,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 32,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,0, 32,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 32,1,0,0,1,0));
        tbl.push_back(v(1,0,0,1,0, 21,1,1,0,0,1));
        tbl.push_back(v(1,0,0,1,0, 21,0,1,1,1,1));
        tbl.push_back(v(1,1,0,0,0, 22,0,1,1,1,0));
        tbl.push_back(v(1,1,0,0,0, 23,0,1,1,1,0));
        tbl.push_back(v(1,1,0,0,0, 24,0,1,1,1,0));
        tbl.push_back(v(1,1,0,0,0, 21,0,1,1,1,0));
        tbl.push_back(v(1,0,1,0,0, 21,1,1,1,1,0));
        tbl.push_back(v(1,1,0,0,0, 22,1,1,1,1,0));
        tbl.push_back(v(1,0,0,1,0, 21,1,1,0,0,1));
        tbl.push_back(v(1,0,0,1,1, 21,1,1,1,1,1));
        tbl.push_back(v(1,1,0,0,0, 22,1,1,1,1,0));
        tbl.push_back(v(0,0,0,1,0, 63,1,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 32,1,0,0,1,0));
        tbl.push_back(v(1,1,0,0,0, 33,1,0,0,1,0));
        tbl.push_back(v(1,1,1,1,0, 21,0,1,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 21,0,1,0,0,0));
        tbl.push_back(v(1,0,1,1,1, 21,1,1,1,1,1));
        tbl.push_back(v(1,1,1,1,0, 21,0,1,0,0,1));
        tbl.push_back(v(0,0,0,0,0, 63,1,0,0,0,0));

        r = v(0,0,0,0,0, 63,1,0,0,0,0);
        r.rstn = 1'b0;
        apply(r);
        apply(r);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset mid-slide with all toggle inputs high, then release without spurious events.
        apply(v(1,0,0,0,0, 32,1,0,0,1,0));
        apply(v(1,0,0,1,0, 21,1,1,0,0,1));
        apply(v(1,0,0,1,0, 21,0,1,1,1,1));
        bus.clk_walk_anim      = 1'b1;
        bus.collapsion_impulse = 1'b1;
        bus.press_impulse      = 1'b1;
        r = v(1,0,0,0,0, 63,1,0,0,0,0);
        r.rstn = 1'b0;
        apply(r);
        apply(r);
        apply(v(1,0,0,0,0, 32,1,0,0,1,0));
        apply(v(1,0,0,0,0, 32,1,0,0,1,0));
        apply(v(1,1,0,0,0, 33,1,0,0,1,0));

        // Mid-wake reset: revive to WAKING, then drop to HIDDEN.
        apply(v(1,0,0,1,0, 21,1,1,0,0,1));
        for (int i = 0; i < 8; i++) apply(v(1,1,0,0,0, 21,1,1,0,0,0));
        apply(v(1,1,0,0,0, 32,1,1,0,0,0));
        r = v(1,0,0,0,0, 63,1,0,0,0,0);
        r.rstn = 1'b0;
        apply(r);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
